// File: rtl/rr_merge_4_1_pkg.sv
// Shared types and constants for the four-source round-robin merger.
package rr_merge_4_1_pkg;
   localparam int N_SRC = 4;
   typedef logic [1:0] src_idx_t;
endpackage

// File: rtl/rr_merge_4_1_pick.sv
// Combinational round-robin picker: rotate requests so ptr sits at bit 0,
// take the lowest set bit, then rotate the offset back to a source index.
module rr_pick_4
   import rr_merge_4_1_pkg::*;
(
   input  logic [N_SRC-1:0] req,
   input  src_idx_t         ptr,
   output logic [N_SRC-1:0] grant_onehot,
   output src_idx_t         grant_idx,
   output logic             any
);
   logic [2*N_SRC-1:0] req2;
   logic [N_SRC-1:0]   rot;
   src_idx_t           offset;

   always_comb begin
      req2   = {req, req};
      rot    = req2[{1'b0, ptr} +: N_SRC];
      offset = '0;
      any    = 1'b0;
      for (int k = N_SRC - 1; k >= 0; k--) begin
         if (rot[k]) begin
            offset = src_idx_t'(k);
            any    = 1'b1;
         end
      end
      grant_idx    = ptr + offset;
      grant_onehot = any ? ({{(N_SRC-1){1'b0}}, 1'b1} << grant_idx) : '0;
   end
endmodule

// File: rtl/rr_merge_4_1.sv
// Four-input round-robin stream merger with a single registered output slot
// that provides the select and payload for the downstream 4:1 mux.
module rr_merge_4_1
   import rr_merge_4_1_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_SRC-1:0]  in_valid,
   input  logic [WIDTH-1:0]  in_data0,
   input  logic [WIDTH-1:0]  in_data1,
   input  logic [WIDTH-1:0]  in_data2,
   input  logic [WIDTH-1:0]  in_data3,
   output logic [N_SRC-1:0]  in_ready,
   output logic              out_valid,
   output logic [WIDTH-1:0]  out_data,
   output logic [1:0]        out_sel,
   input  logic              out_ready
);
   logic [WIDTH-1:0] data_arr [N_SRC];
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;
   src_idx_t         sel_q, sel_d;
   src_idx_t         ptr_q, ptr_d;
   logic             load_en;
   logic [N_SRC-1:0] grant_onehot;
   src_idx_t         grant_idx;
   logic             grant_any;

   assign data_arr[0] = in_data0;
   assign data_arr[1] = in_data1;
   assign data_arr[2] = in_data2;
   assign data_arr[3] = in_data3;

   rr_pick_4 u_pick (
      .req          (in_valid),
      .ptr          (ptr_q),
      .grant_onehot (grant_onehot),
      .grant_idx    (grant_idx),
      .any          (grant_any)
   );

   // Slot is free if empty or being drained this cycle: no bubble on refill.
   assign load_en  = !valid_q || out_ready;
   assign in_ready = (load_en && !rst) ? grant_onehot : '0;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      if (load_en) begin
         if (grant_any) begin
            valid_d = 1'b1;
            data_d  = data_arr[grant_idx];
            sel_d   = grant_idx;
            ptr_d   = grant_idx + src_idx_t'(1);
         end else begin
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         sel_q   <= '0;
         ptr_q   <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_sel   = sel_q;
endmodule

// File: tb/tb_rr_merge_4_1.sv
// Self-checking bench for rr_merge_4_1: directed scenarios plus a randomized
// run against a queue-based reference model with a fairness monitor.
module tb_rr_merge_4_1;
   logic       clk;
   logic       rst;
   logic [3:0] in_valid;
   logic [3:0] in_data [4];
   logic [3:0] in_ready;
   logic       out_valid;
   logic [3:0] out_data;
   logic [1:0] out_sel;
   logic       out_ready;

   int checks = 0;
   int errors = 0;

   // reference model state
   bit         m_valid;
   logic [3:0] m_data;
   int         m_sel;
   int         m_ptr;

   rr_merge_4_1 #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data0  (in_data[0]),
      .in_data1  (in_data[1]),
      .in_data2  (in_data[2]),
      .in_data3  (in_data[3]),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int pick(logic [3:0] v, int p);
      for (int k = 0; k < 4; k++)
         if (v[(p + k) % 4]) return (p + k) % 4;
      return -1;
   endfunction

   function automatic logic [3:0] exp_ready();
      int w;
      logic [3:0] r;
      r = 4'b0;
      if (rst) return r;
      w = pick(in_valid, m_ptr);
      if ((!m_valid || out_ready) && w >= 0) r[w] = 1'b1;
      return r;
   endfunction

   task automatic model_edge();
      int w;
      if (rst) begin
         m_valid = 0; m_data = 4'h0; m_sel = 0; m_ptr = 0;
      end else if (!m_valid || out_ready) begin
         w = pick(in_valid, m_ptr);
         if (w >= 0) begin
            m_valid = 1; m_data = in_data[w]; m_sel = w; m_ptr = (w + 1) % 4;
         end else begin
            m_valid = 0;
         end
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 4'b0; out_ready = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) in_data[i] = 4'(i + 1);
      for (int c = 0; c < 2; c++) begin
         #1;
         checks++;
         if (in_ready !== 4'b0000) begin
            errors++; $display("FAIL reset_in_ready: got %b want 0000", in_ready);
         end
         tick();
         checks++;
         if (out_valid !== 1'b0 || out_sel !== 2'd0 || out_data !== 4'h0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b s=%0d d=%h want v=0 s=0 d=0",
                     out_valid, out_sel, out_data);
         end
      end
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 4'b0001) begin
         errors++; $display("FAIL reset_first_ready: got %b want 0001", in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 4'h1) begin
         errors++;
         $display("FAIL reset_first_grant: got v=%b s=%0d d=%h want v=1 s=0 d=1",
                  out_valid, out_sel, out_data);
      end
   endtask

   task automatic test_contention();
      int es[6];
      int ed[6];
      es = '{0, 1, 2, 3, 0, 1};
      ed = '{1, 2, 3, 4, 1, 2};
      do_reset();
      in_valid = 4'b1111; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) in_data[i] = 4'(i + 1);
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_sel !== 2'(es[i]) || out_data !== 4'(ed[i])) begin
            errors++;
            $display("FAIL contention[%0d]: got v=%b s=%0d d=%h want v=1 s=%0d d=%h",
                     i, out_valid, out_sel, out_data, es[i], ed[i]);
         end
      end
   endtask

   task automatic test_wrap_skip();
      int es[3];
      es = '{0, 2, 0};
      do_reset();
      in_valid = 4'b1111; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) in_data[i] = 4'(i + 8);
      repeat (3) tick();
      in_valid = 4'b0101;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (out_sel !== 2'(es[i]) || out_data !== 4'(es[i] + 8)) begin
            errors++;
            $display("FAIL wrap_skip[%0d]: got s=%0d d=%h want s=%0d d=%h",
                     i, out_sel, out_data, es[i], es[i] + 8);
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      in_valid = 4'b0001; in_data[0] = 4'hA; out_ready = 1'b1;
      tick();
      out_ready = 1'b0; in_valid = 4'b1111;
      in_data[1] = 4'h6; in_data[2] = 4'h7; in_data[3] = 4'h8;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (in_ready !== 4'b0000) begin
            errors++; $display("FAIL stall_ready[%0d]: got %b want 0000", c, in_ready);
         end
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_data !== 4'hA || out_sel !== 2'd0) begin
            errors++;
            $display("FAIL stall_hold[%0d]: got v=%b s=%0d d=%h want v=1 s=0 d=a",
                     c, out_valid, out_sel, out_data);
         end
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 4'b0010) begin
         errors++; $display("FAIL release_ready: got %b want 0010", in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 4'h6 || out_sel !== 2'd1) begin
         errors++;
         $display("FAIL release_load: got v=%b s=%0d d=%h want v=1 s=1 d=6",
                  out_valid, out_sel, out_data);
      end
   endtask

   task automatic test_idle_drain();
      do_reset();
      in_valid = 4'b0001; in_data[0] = 4'h3; out_ready = 1'b1;
      tick();
      in_valid = 4'b0000;
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_data !== 4'h3) begin
         errors++;
         $display("FAIL idle_drain: got v=%b d=%h want v=0 d=3", out_valid, out_data);
      end
      in_valid = 4'b0100; in_data[2] = 4'hC;
      #1;
      checks++;
      if (in_ready !== 4'b0100) begin
         errors++; $display("FAIL idle_ready: got %b want 0100", in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 4'hC) begin
         errors++;
         $display("FAIL idle_refill: got v=%b s=%0d d=%h want v=1 s=2 d=c",
                  out_valid, out_sel, out_data);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      in_valid = 4'b1111; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) in_data[i] = 4'(i + 1);
      repeat (2) tick();
      out_ready = 1'b0; rst = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_sel !== 2'd0 || out_data !== 4'h0) begin
         errors++;
         $display("FAIL midreset_clear: got v=%b s=%0d d=%h want v=0 s=0 d=0",
                  out_valid, out_sel, out_data);
      end
      rst = 1'b0; out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 4'b0001) begin
         errors++; $display("FAIL midreset_ready: got %b want 0001", in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 4'h1) begin
         errors++;
         $display("FAIL midreset_restart: got v=%b s=%0d d=%h want v=1 s=0 d=1",
                  out_valid, out_sel, out_data);
      end
   endtask

   task automatic test_random();
      bit         pend[4];
      int         waits[4];
      logic [3:0] sbq[$];
      logic [3:0] er;
      logic [3:0] exp_word;
      int         w;
      do_reset();
      for (int i = 0; i < 4; i++) begin pend[i] = 0; waits[i] = 0; end
      for (int c = 0; c < 2000; c++) begin
         for (int i = 0; i < 4; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i] = 1;
               in_data[i] = 4'($urandom_range(0, 15));
            end
         end
         in_valid  = {pend[3], pend[2], pend[1], pend[0]};
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         er = exp_ready();
         checks++;
         if (in_ready !== er) begin
            errors++; $display("FAIL rand_ready[%0d]: got %b want %b", c, in_ready, er);
         end
         if (m_valid && out_ready) begin
            exp_word = (sbq.size() > 0) ? sbq.pop_front() : 4'hx;
            checks++;
            if (out_data !== exp_word) begin
               errors++;
               $display("FAIL rand_stream[%0d]: got %h want %h", c, out_data, exp_word);
            end
         end
         w = -1;
         for (int i = 0; i < 4; i++) if (er[i]) w = i;
         if (w >= 0) begin
            sbq.push_back(in_data[w]);
            for (int j = 0; j < 4; j++) begin
               if (pend[j] && j != w) begin
                  waits[j]++;
                  checks++;
                  if (waits[j] > 3) begin
                     errors++;
                     $display("FAIL rand_fair[%0d]: src %0d waited %0d transfers, limit 3",
                              c, j, waits[j]);
                  end
               end
            end
            waits[w] = 0;
         end
         tick();
         if (w >= 0) pend[w] = 0;
         checks++;
         if (out_valid !== m_valid ||
             (m_valid && (out_data !== m_data || out_sel !== 2'(m_sel)))) begin
            errors++;
            $display("FAIL rand_out[%0d]: got v=%b s=%0d d=%h want v=%0d s=%0d d=%h",
                     c, out_valid, out_sel, out_data, m_valid, m_sel, m_data);
         end
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 4'b0; out_ready = 1'b0;
      for (int i = 0; i < 4; i++) in_data[i] = 4'h0;
      m_valid = 0; m_data = 4'h0; m_sel = 0; m_ptr = 0;
      test_reset();
      test_contention();
      test_wrap_skip();
      test_backpressure();
      test_idle_drain();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/rr_merge_4_1.md
Name: rr_merge_4_1

Overview:
- Four-input round-robin stream merger; feeds the 4-bit 4:1 data mux stage with a registered select and registered payload.
- Arbitrates among four valid/ready producers, captures the winner's word into a single output register, and presents it downstream with valid/ready.
- Sits directly upstream of the select-driven mux datapath.
- Produces `out_sel` as the mux select and `out_data` as the merged payload.

Parameters:
- WIDTH, 4, payload width of each input and of out_data.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  4  per-source valid; bit i belongs to source i.
- in_data0  input  WIDTH  source 0 payload.
- in_data1  input  WIDTH  source 1 payload.
- in_data2  input  WIDTH  source 2 payload.
- in_data3  input  WIDTH  source 3 payload.
- in_ready  output  4  per-source ready (combinational); at most one bit high.
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered winning payload.
- out_sel  output  2  registered index of the source that produced out_data.
- out_ready  input  1  downstream accepts out_data this cycle.

Behaviour:
- One clock domain.
- Reset is synchronous, active-high, sampled on the clk rising edge.
- Reset values: out_valid=0, out_data=0, out_sel=0, priority pointer ptr=0.
  - in_ready=0 while rst=1.
- load_en = !out_valid || out_ready. The register is empty or drains this cycle, so throughput is 1 word/cycle with no bubble.
- Arbitration (combinational): scan sources ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first with in_valid=1 is the winner w.
- in_ready[w] = load_en; all other in_ready bits are 0.
- in_ready never depends on any in_valid bit other than through the arbitration pick.
- Transfer when load_en && |in_valid. At the next edge:
  - out_valid<=1, out_data<=in_data[w], out_sel<=w.
  - ptr<=(w+1) mod 4. 3 wraps to 0 via the natural 2-bit overflow.
- load_en && !(|in_valid): out_valid<=0; out_data, out_sel and ptr hold.
- Stall (out_valid && !out_ready): in_ready=0. out_valid, out_data and out_sel hold stable. ptr holds.
- Latency: input accept edge to out_valid=1 is 1 cycle.
- Fairness: a source holding in_valid=1 is granted within at most 4 transfers, i.e. at most 3 other transfers precede it.
- Input contract: a source keeps in_valid and its data stable until in_ready is seen. The block itself tolerates valid being withdrawn, because the pick is recomputed each cycle.
- Simultaneous drain and refill (out_valid && out_ready && |in_valid): the new word replaces the old in the same edge. No loss, no duplicate.
- Reset mid-operation: the held word is discarded. out_valid=0 on the edge after rst is sampled high. ptr returns to 0. Arbitration restarts from source 0.
- out_data is left unchanged when out_valid=0 (not cleared), except by reset.

Decomposition:
- Shared package holds:
  - localparam N_SRC=4.
  - typedef logic [1:0] src_idx_t for out_sel and ptr.
- One sub-module, rr_pick_4:
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: grant_onehot[3:0], grant_idx[1:0], any.
  - Purely combinational rotate / priority-encode / unrotate.
- The top level holds ptr, the output register and the handshake logic.

Test Plan:
- Reset: drive rst=1 for 2 cycles with in_valid=4'b1111 → in_ready=0, out_valid=0, out_sel=0, out_data=0. After release, the first grant goes to source 0.
- Full contention, out_ready=1: in_valid=4'b1111, data 4'h1/4'h2/4'h3/4'h4 → out_sel sequence 0,1,2,3,0,1 on consecutive cycles and out_data 1,2,3,4,1,2.
- Wrap and skip: ptr=3 (after granting 2), in_valid=4'b0101 → grant source 0, then source 2. Source 3 is never granted when idle.
- Backpressure: hold out_ready=0 for 3 cycles with out_valid=1, out_data=4'hA → in_ready=0 and out_data, out_sel and ptr unchanged. Raise out_ready → 4'hA consumed and the next winner loaded the same edge.
- Idle drain: one word held, out_ready=1, in_valid=0 → out_valid falls to 0 next cycle. ptr unchanged. The next single request on source 2 appears with out_sel=2 one cycle after acceptance.
- Reset mid-stream: assert rst while out_valid=1 and sources pending → out_valid=0 next edge, no word emitted twice. After release, arbitration restarts at source 0.
